// File: rtl/iterdiv_pkg.sv
// iterdiv_pkg
// Shared types and sizing for the iterative divide/remainder unit.
//   op_e    : RV32M divide opcode, encoded as funct3[1:0]
//   state_e : controller state
//   cnt_width() : bits needed to hold an iteration count of 0..w
package iterdiv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/iterdiv_divstep.sv
// iterdiv_divstep
// One combinational restoring-division iteration.
//   rem      in  : partial remainder (always < divisor)
//   quo      in  : remaining dividend bits / quotient bits collected so far
//   divisor  in  : divisor magnitude
//   rem_nx   out : partial remainder after this step
//   quo_nx   out : quotient register after this step (new bit in LSB)
module iterdiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    // rem < divisor, so the shifted remainder is below 2*divisor. The MSB of
    // the (WIDTH+1)-bit difference is therefore clear exactly when it fits.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, divisor};
    assign fits   = ~diff[WIDTH];

    assign rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/iterdiv.sv
// iterdiv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (op, dividend, divisor)
//   kill                : flush, abandons any in-flight operation
//   out_valid/out_ready : result handshake
//   result              : registered quotient or remainder
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | restoring iterations, counter counts WIDTH down to 1
// FIX   | sign fix-up and quotient/remainder select into result
// DONE  | result held until the consumer takes it
module iterdiv
    import iterdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, div_mag;
    logic             neg_q, neg_r, sel_rem;

    op_e              op_in;
    logic             is_signed, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, overflow, special;
    logic [WIDTH-1:0] special_val;
    logic             accept;

    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] fixed_val;

    assign op_in     = op_e'(op);
    assign is_signed = (op_in == DIV) || (op_in == REM);
    assign sign_a    = is_signed & dividend[WIDTH-1];
    assign sign_b    = is_signed & divisor[WIDTH-1];
    assign mag_a     = sign_a ? (WIDTH'(0) - dividend) : dividend;
    assign mag_b     = sign_b ? (WIDTH'(0) - divisor) : divisor;

    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special   = div_zero || overflow;

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = op[1] ? dividend : '1;
        else
            special_val = op[1] ? '0 : MIN_NEG;
    end

    assign fixed_val = sel_rem ? (neg_r ? (WIDTH'(0) - rem) : rem)
                               : (neg_q ? (WIDTH'(0) - quo) : quo);

    assign in_ready = (state == IDLE) && !reset;

    iterdiv_divstep #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (div_mag),
        .rem_nx  (rem_nx),
        .quo_nx  (quo_nx)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready && !kill) begin
                    accept   = 1'b1;
                    state_nx = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(1))
                    state_nx = FIX;
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A flush wins over everything, including a same-cycle handshake.
        if (kill)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            div_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sel_rem   <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (state_nx == DONE);
            if (accept) begin
                sel_rem <= op[1];
                neg_q   <= sign_a ^ sign_b;
                neg_r   <= sign_a;
                div_mag <= mag_b;
                rem     <= '0;
                quo     <= mag_a;
                if (special) begin
                    cnt    <= '0;
                    result <= special_val;
                end else begin
                    cnt    <= CW'(WIDTH);
                end
            end else if (state == BUSY) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt - CW'(1);
            end else if (state == FIX) begin
                result <= fixed_val;
            end
        end
    end

endmodule

// File: tb/tb_iterdiv.sv
module tb_iterdiv;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          kill;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iterdiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics straight from the arithmetic rules.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic sgn;
        sgn = (o == 2'b00) || (o == 2'b10);
        if (b == 0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == MINV && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : MINV;
        if (sgn)
            return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        logic sgn;
        sgn = (o == 2'b00) || (o == 2'b10);
        if (b == 0 || (sgn && a == MINV && b == 32'hFFFF_FFFF))
            return 1;
        return W + 2;
    endfunction

    // Issue one request, wait for out_valid, hold it `hold` cycles, then take it.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int cyc;
        exp = ref_result(o, a, b);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 100);
        chk({tag, "_lat"}, 32'(cyc), 32'(ref_latency(o, a, b)));
        chk({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_res"}, result, exp);
            chk({tag, "_hold_busy"}, {30'd0, out_valid, in_ready}, 32'b10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_after"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    // Start an op and abort it at the given BUSY cycle by kill (use_reset=0) or reset.
    task automatic abort_op(input string tag, input int at_cycle, input bit use_reset);
        int seen;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (at_cycle) @(negedge clk);
        if (use_reset) reset = 1'b1; else kill = 1'b1;
        @(posedge clk);
        #1 begin reset = 1'b0; kill = 1'b0; end
        @(negedge clk);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk({tag, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        kill = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, out_valid, in_ready, 1'b0}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("divu_5_0",   2'b01, 32'd5, 32'd0, 0);
        do_op("remu_5_0",   2'b11, 32'd5, 32'd0, 0);
        do_op("div_m5_0",   2'b00, 32'hFFFF_FFFB, 32'd0, 0);
        do_op("div_ovf",    2'b00, MINV, 32'hFFFF_FFFF, 0);
        do_op("rem_ovf",    2'b10, MINV, 32'hFFFF_FFFF, 0);
        do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5);

        // kill together with in_valid in IDLE must not start anything
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk);
        #1 begin in_valid = 1'b0; kill = 1'b0; end
        @(negedge clk);
        chk("kill_idle", {30'd0, out_valid, in_ready}, 32'b01);

        abort_op("kill_b10", 10, 1'b0);
        abort_op("rst_b20", 20, 1'b1);
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

        // kill in DONE alongside out_ready: result dropped, unit back in IDLE
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; dividend = 32'd7; divisor = 32'd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("kdone_valid", 32'(out_valid), 32'd1);
        kill = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 begin kill = 1'b0; out_ready = 1'b0; end
        @(negedge clk);
        chk("kdone_after", {30'd0, out_valid, in_ready}, 32'b01);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = rb | 32'h8000_0000;
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ro, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
